// File: rtl/mem_xfer_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_xfer_regs_if
// Brief    : Memory-port bundle between mem_xfer_regs and the RAM model.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_xfer_regs_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_size;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_addr, mem_wdata, mem_size, mem_req, mem_we,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_size, mem_req, mem_we,
    output mem_rdata, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_xfer_regs.sv
`default_nettype none
// ============================================================================
// Module   : mem_xfer_regs
// Brief    : MAR/MDR registers plus memory handshake with timeout and
//            byte/halfword/word read extension.
// Revision : 1.0 - initial release
// ============================================================================
module mem_xfer_regs #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  wire logic              CLK,
  input  wire logic              RST,
  input  wire logic              MARLd,
  input  wire logic              MDRLd,
  input  wire logic [DATA_W-1:0] Ds,
  input  wire logic              MFA,
  input  wire logic              RW,
  input  wire logic [1:0]        Size,
  input  wire logic              SignExt,
  mem_xfer_regs_if.master        mem,
  output logic [ADDR_W-1:0]      MAR_Q,
  output logic [DATA_W-1:0]      MDR_Q,
  output logic                   MOC,
  output logic                   err,
  output logic                   busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    FAIL = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_q,   mar_d;
  logic [DATA_W-1:0] mdr_q,   mdr_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [1:0]        size_q,  size_d;
  logic              rw_q,    rw_d;
  logic              sext_q,  sext_d;
  logic [DATA_W-1:0] rdata_ext;

  // Sub-word reads always come from the low lanes; only the fill differs.
  always_comb begin
    rdata_ext = mem.mem_rdata;
    case (size_q)
      2'b00: begin
        for (int i = 8; i < DATA_W; i++) begin
          rdata_ext[i] = sext_q & mem.mem_rdata[7];
        end
      end
      2'b01: begin
        for (int i = 16; i < DATA_W; i++) begin
          rdata_ext[i] = sext_q & mem.mem_rdata[15];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    rw_d    = rw_q;
    sext_d  = sext_q;
    case (state_q)
      IDLE: begin
        if (MARLd) mar_d = ADDR_W'(Ds);
        if (MDRLd) mdr_d = Ds;
        if (MFA) begin
          rw_d    = RW;
          size_d  = Size;
          sext_d  = SignExt;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // An ack on the last allowed cycle takes priority over the timeout.
        if (mem.mem_ack) begin
          if (rw_q) mdr_d = rdata_ext;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = FAIL;
        end
      end
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      rw_q    <= 1'b0;
      sext_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      rw_q    <= rw_d;
      sext_q  <= sext_d;
    end
  end

  assign mem.mem_addr  = mar_q;
  assign mem.mem_wdata = mdr_q;
  assign mem.mem_size  = size_q;
  assign mem.mem_req   = (state_q == REQ);
  assign mem.mem_we    = (state_q == REQ) && !rw_q;

  assign MAR_Q = mar_q;
  assign MDR_Q = mdr_q;
  assign MOC   = (state_q == DONE) || (state_q == FAIL);
  assign err   = (state_q == FAIL);
  assign busy  = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_xfer_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_xfer_regs
// Brief    : Directed scoreboard bench for mem_xfer_regs (TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_xfer_regs;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          MARLd = 1'b0;
  logic          MDRLd = 1'b0;
  logic [DW-1:0] Ds = '0;
  logic          MFA = 1'b0;
  logic          RW = 1'b0;
  logic [1:0]    Size = 2'b00;
  logic          SignExt = 1'b0;
  logic [AW-1:0] MAR_Q;
  logic [DW-1:0] MDR_Q;
  logic          MOC;
  logic          err;
  logic          busy;

  mem_xfer_regs_if #(.DATA_W(DW), .ADDR_W(AW)) mem_if ();

  mem_xfer_regs #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .MARLd   (MARLd),
    .MDRLd   (MDRLd),
    .Ds      (Ds),
    .MFA     (MFA),
    .RW      (RW),
    .Size    (Size),
    .SignExt (SignExt),
    .mem     (mem_if),
    .MAR_Q   (MAR_Q),
    .MDR_Q   (MDR_Q),
    .MOC     (MOC),
    .err     (err),
    .busy    (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        err;
    logic [31:0] mdr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  size;
    logic [7:0]  reqs;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          ack_at = 0;
  int          resp_n = 0;
  int          mon_reqs = 0;
  logic        ack_r = 1'b0;
  logic [31:0] rdata = '0;

  assign mem_if.mem_ack   = ack_r;
  assign mem_if.mem_rdata = rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: acknowledges on the ack_at-th request cycle (0 = never).
  always @(negedge CLK) begin
    if (mem_if.mem_req) begin
      resp_n++;
      ack_r = (ack_at != 0) && (resp_n == ack_at);
    end else begin
      resp_n = 0;
      ack_r  = 1'b0;
    end
  end

  // Monitor: checks the bus during requests and pops an expectation per MOC.
  always @(negedge CLK) begin
    if (mem_if.mem_req) begin
      mon_reqs++;
      if (sb.size() > 0) begin
        check("mem_addr",  mem_if.mem_addr,         sb[0].addr);
        check("mem_wdata", mem_if.mem_wdata,        sb[0].wdata);
        check("mem_we",    32'(mem_if.mem_we),      32'(sb[0].we));
        check("mem_size",  32'(mem_if.mem_size),    32'(sb[0].size));
      end
    end
    if (MOC) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_moc: got MOC=1 expected no completion");
      end else begin
        mon_e = sb.pop_front();
        check("err",        32'(err),      32'(mon_e.err));
        check("mdr",        MDR_Q,         mon_e.mdr);
        check("req_cycles", 32'(mon_reqs), 32'(mon_e.reqs));
      end
    end
    if (!mem_if.mem_req && !MOC) mon_reqs = 0;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic xfer(input logic rw, input logic [1:0] sz, input logic sx,
                      input logic [31:0] rd, input int ack, input exp_t e);
    sb.push_back(e);
    rdata   = rd;
    ack_at  = ack;
    RW      = rw;
    Size    = sz;
    SignExt = sx;
    MFA     = 1'b1;
    tick();
    MFA     = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (busy) begin
      fails++;
      $display("FAIL wait_idle: got busy=1 expected idle within 20 cycles");
    end
  endtask

  initial begin
    repeat (2) tick();
    RST = 1'b0;
    check("rst_mar",  MAR_Q,                  32'h0);
    check("rst_mdr",  MDR_Q,                  32'h0);
    check("rst_busy", 32'(busy),              32'h0);
    check("rst_moc",  32'(MOC),               32'h0);
    check("rst_req",  32'(mem_if.mem_req),    32'h0);
    check("rst_size", 32'(mem_if.mem_size),   32'h0);

    // Reset in the second REQ cycle aborts without MOC
    Ds = 32'h200; MARLd = 1'b1; tick(); MARLd = 1'b0;
    Ds = 32'h1234; MDRLd = 1'b1; tick(); MDRLd = 1'b0;
    ack_at = 0; RW = 1'b1; Size = 2'b10; MFA = 1'b1; tick(); MFA = 1'b0;
    tick();
    RST = 1'b1; tick(); RST = 1'b0;
    check("abort_req",  32'(mem_if.mem_req), 32'h0);
    check("abort_busy", 32'(busy),           32'h0);
    check("abort_mar",  MAR_Q,               32'h0);
    check("abort_mdr",  MDR_Q,               32'h0);
    check("abort_moc",  32'(MOC),            32'h0);
    repeat (3) tick();

    // Word write, ack on third request cycle
    Ds = 32'h100; MARLd = 1'b1; tick(); MARLd = 1'b0;
    Ds = 32'hDEADBEEF; MDRLd = 1'b1; tick(); MDRLd = 1'b0;
    xfer(1'b0, 2'b10, 1'b0, 32'h0, 3,
         '{err:1'b0, mdr:32'hDEADBEEF, addr:32'h100, wdata:32'hDEADBEEF, we:1'b1, size:2'b10, reqs:8'd3});
    wait_idle();

    // Signed byte read, immediate ack: MOC two cycles after MFA
    xfer(1'b1, 2'b00, 1'b1, 32'h12345680, 1,
         '{err:1'b0, mdr:32'hFFFFFF80, addr:32'h100, wdata:32'hDEADBEEF, we:1'b0, size:2'b00, reqs:8'd1});
    tick();
    check("moc_latency", 32'(MOC), 32'h1);
    wait_idle();

    xfer(1'b1, 2'b00, 1'b0, 32'h12345680, 1,
         '{err:1'b0, mdr:32'h00000080, addr:32'h100, wdata:32'hFFFFFF80, we:1'b0, size:2'b00, reqs:8'd1});
    wait_idle();
    xfer(1'b1, 2'b01, 1'b1, 32'h00008001, 1,
         '{err:1'b0, mdr:32'hFFFF8001, addr:32'h100, wdata:32'h00000080, we:1'b0, size:2'b01, reqs:8'd1});
    wait_idle();
    xfer(1'b1, 2'b00, 1'b1, 32'hABCDEF7F, 1,
         '{err:1'b0, mdr:32'h0000007F, addr:32'h100, wdata:32'hFFFF8001, we:1'b0, size:2'b00, reqs:8'd1});
    wait_idle();
    xfer(1'b1, 2'b01, 1'b0, 32'h1234F00D, 2,
         '{err:1'b0, mdr:32'h0000F00D, addr:32'h100, wdata:32'h0000007F, we:1'b0, size:2'b01, reqs:8'd2});
    wait_idle();

    // Timeout with no ack, then ack on the final allowed cycle
    xfer(1'b1, 2'b10, 1'b0, 32'hCAFEBABE, 0,
         '{err:1'b1, mdr:32'h0000F00D, addr:32'h100, wdata:32'h0000F00D, we:1'b0, size:2'b10, reqs:8'd4});
    wait_idle();
    xfer(1'b1, 2'b10, 1'b0, 32'h11223344, 4,
         '{err:1'b0, mdr:32'h11223344, addr:32'h100, wdata:32'h0000F00D, we:1'b0, size:2'b10, reqs:8'd4});
    wait_idle();

    // Loads and a second MFA during REQ are ignored
    xfer(1'b0, 2'b10, 1'b0, 32'h0, 3,
         '{err:1'b0, mdr:32'h11223344, addr:32'h100, wdata:32'h11223344, we:1'b1, size:2'b10, reqs:8'd3});
    Ds = 32'h55; MARLd = 1'b1; MDRLd = 1'b1; MFA = 1'b1;
    tick(); tick();
    MARLd = 1'b0; MDRLd = 1'b0; MFA = 1'b0;
    wait_idle();
    check("lock_mar", MAR_Q, 32'h100);
    check("lock_mdr", MDR_Q, 32'h11223344);

    // MARLd together with MFA in IDLE: the transfer uses the new address
    Ds = 32'h40; MARLd = 1'b1;
    xfer(1'b1, 2'b10, 1'b1, 32'hA5A5A5A5, 2,
         '{err:1'b0, mdr:32'hA5A5A5A5, addr:32'h40, wdata:32'h11223344, we:1'b0, size:2'b10, reqs:8'd2});
    MARLd = 1'b0;
    wait_idle();
    check("same_edge_mar", MAR_Q, 32'h40);

    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_xfer_regs.md
Name: mem_xfer_regs

Overview:
- Parametrised successor to the single load-enable MAR/MDR registers.
- Holds the memory address register and the memory data register, and runs the memory handshake for them.
- The control unit loads MAR/MDR, then pulses MFA to start a transaction. The block drives the memory port, waits for acknowledge with a timeout, and returns MOC.
- Supports byte, halfword and word reads with sign or zero extension. Sits between the datapath bus and the memory/RAM model.

Parameters:
DATA_W, 32, width of MDR, Ds, mem_wdata and mem_rdata.
ADDR_W, 32, width of MAR and mem_addr.
TIMEOUT, 16, number of mem_req cycles without ack before the transfer aborts (>=1).

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RST  in  1  synchronous, active-high reset.
MARLd  in  1  load MAR from Ds[ADDR_W-1:0] (IDLE only).
MDRLd  in  1  load MDR from Ds (IDLE only).
Ds  in  DATA_W  datapath bus input.
MFA  in  1  memory function activate; starts a transfer.
RW  in  1  1 = read, 0 = write; sampled with MFA.
Size  in  2  00 byte, 01 halfword, 10/11 word; sampled with MFA.
SignExt  in  1  1 = sign-extend sub-word reads; sampled with MFA.
mem_addr  out  ADDR_W  equals MAR_Q.
mem_wdata  out  DATA_W  equals MDR_Q.
mem_size  out  2  latched Size.
mem_req  out  1  request, held high in REQ state.
mem_we  out  1  high in REQ when the latched RW = 0.
mem_rdata  in  DATA_W  read data, valid when mem_ack = 1.
mem_ack  in  1  memory completion.
MAR_Q  out  ADDR_W  MAR contents.
MDR_Q  out  DATA_W  MDR contents.
MOC  out  1  one-cycle completion pulse to the control unit.
err  out  1  one-cycle pulse coincident with MOC on timeout.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: RST sampled high forces the following, overriding everything including mid-transfer:
  - MAR_Q = 0, MDR_Q = 0, mem_size = 0, timeout counter = 0.
  - State = IDLE.
  - mem_req, mem_we, MOC, err and busy all low from the next cycle.
  - No MOC is produced for an aborted transfer.
- States: IDLE, REQ, DONE, FAIL.
- IDLE:
  - MARLd and MDRLd load their registers at the edge.
  - MFA = 1 latches RW, Size and SignExt, clears the counter, and moves to REQ.
  - MARLd/MDRLd asserted at the same edge as MFA take effect. The transfer uses the new MAR/MDR values.
- REQ:
  - mem_req = 1; mem_we = !RW_latched.
  - MARLd, MDRLd and MFA are ignored.
  - mem_ack = 1 at an edge:
    - Read: MDR <= extended mem_rdata.
    - Write: MDR is unchanged.
    - Next state DONE.
  - No ack: counter increments. If the counter equals TIMEOUT-1 at that edge, next state is FAIL and MDR is unchanged.
  - Ack on the final allowed cycle wins over timeout.
- DONE: MOC = 1 for exactly one cycle, then IDLE.
- FAIL: MOC = 1 and err = 1 for exactly one cycle, then IDLE.
- MFA held high through DONE/FAIL starts a new transfer only when it is sampled in IDLE, i.e. the cycle after MOC.
- Latency:
  - mem_req rises one cycle after MFA is sampled.
  - MOC rises one cycle after mem_ack is sampled.
  - Minimum MFA-to-MOC is 2 cycles with ack in the first REQ cycle.
- Read extension (DATA_W >= 16):
  - Byte uses mem_rdata[7:0], halfword uses mem_rdata[15:0], word uses it unmodified.
  - Upper bits are filled with the top bit of the field if SignExt = 1, else with zeros.
  - Data is always taken from the low lanes; alignment is the memory's job.
- mem_ack outside REQ is ignored.

Test Plan:
- Reset mid-transfer: MFA read, then RST in the 2nd REQ cycle -> next cycle mem_req = 0, busy = 0, MAR_Q = MDR_Q = 0, no MOC.
- Word write: Ds = 0x100 with MARLd; Ds = 0xDEADBEEF with MDRLd; MFA, RW = 0; ack on the 3rd REQ cycle -> 3 cycles of mem_req = mem_we = 1, mem_addr = 0x100, mem_wdata = 0xDEADBEEF, single MOC, MDR_Q unchanged.
- Signed byte read: Size = 00, SignExt = 1, mem_rdata = 0x12345680 with immediate ack -> MDR_Q = 0xFFFFFF80, MOC 2 cycles after MFA. Repeat with SignExt = 0 -> 0x00000080. Halfword signed with 0x0000_8001 -> 0xFFFF8001.
- Timeout: TIMEOUT = 4, mem_ack held 0 -> mem_req high exactly 4 cycles, then MOC = err = 1 for one cycle, MDR_Q unchanged. Ack on the 4th cycle -> MOC without err.
- Busy lockout: MARLd with Ds = 0x55 and a second MFA asserted during REQ -> MAR_Q unchanged, exactly one MOC. Simultaneous MARLd + MFA in IDLE with Ds = 0x40 -> mem_addr = 0x40 during REQ.
